// File: rtl/processor_pkg.sv
// processor_pkg: instruction field layout, opcode classes and operand-use decode shared by the pipeline
package processor_pkg;
  localparam int NUM_REGS = 32;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam logic [5:0] OP_NOP = 6'h3F;
  typedef enum logic [1:0] {CLS_R = 2'b00, CLS_I = 2'b01, CLS_ST = 2'b10, CLS_BR = 2'b11} cls_e;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_e;
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic        writes;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
  } id_pkt_t;
  function automatic logic uses_rs1(input logic [5:0] op);
    return op != OP_NOP;
  endfunction
  function automatic logic uses_rs2(input logic [5:0] op);
    return op != OP_NOP && cls_e'(op[5:4]) != CLS_I;
  endfunction
  function automatic logic writes_rd(input logic [5:0] op);
    return op != OP_NOP && (cls_e'(op[5:4]) == CLS_R || cls_e'(op[5:4]) == CLS_I);
  endfunction
endpackage

// File: rtl/pending_write_scoreboard.sv
// pending_write_scoreboard: per-register 2-bit count of issued writes not yet written back
module pending_write_scoreboard
  import processor_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       inc_en,
  input  logic [4:0] inc_idx,
  input  logic       dec_en,
  input  logic [4:0] dec_idx,
  input  logic [4:0] qa,
  input  logic [4:0] qb,
  input  logic [4:0] qrd,
  output logic       busy_a,
  output logic       busy_b,
  output logic       sat_rd
);
  logic [NUM_REGS-1:0][1:0] cnt_q, cnt_d;
  logic [NUM_REGS-1:0]      inc_v, dec_v;
  // Net change per register; an inc and dec on the same register cancel, r0 never counts
  always_comb begin
    inc_v = inc_en ? NUM_REGS'(1) << inc_idx : '0;
    dec_v = (dec_en && dec_idx != 5'd0) ? NUM_REGS'(1) << dec_idx : '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_d[i] = (inc_v[i] && !dec_v[i] && cnt_q[i] != 2'd3) ? cnt_q[i] + 2'd1 :
                 (dec_v[i] && !inc_v[i] && cnt_q[i] != 2'd0) ? cnt_q[i] - 2'd1 : cnt_q[i];
  end
  // Counter state, dropped immediately on reset
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  assign busy_a = cnt_q[qa] != 2'd0;
  assign busy_b = cnt_q[qb] != 2'd0;
  assign sat_rd = cnt_q[qrd] == 2'd3;
endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: one-slot decode/issue with RAW/WAW interlock ahead of the register file
module decode_issue_stage
  import processor_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic [4:0]  RA,
  output logic [4:0]  RB,
  input  logic [31:0] BusA,
  input  logic [31:0] BusB,
  input  logic        wb_enable,
  input  logic [4:0]  wb_rw,
  input  logic        flush,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rd,
  output logic        id_writes,
  output logic [31:0] id_imm,
  output logic [31:0] id_a,
  output logic [31:0] id_b,
  output logic [31:0] id_pc
);
  slot_e       slot_q, slot_d;
  out_e        out_q, out_d;
  logic [31:0] instr_q, instr_d, pc_q, pc_d;
  id_pkt_t     pkt_q, pkt_d;
  logic [5:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic        full, use_a, use_b, writes, busy_a, busy_b, sat_rd, hazard, issue, accept;
  assign op     = instr_q[OP_HI:OP_LO];
  assign rd     = instr_q[RD_HI:RD_LO];
  assign rs1    = instr_q[RS1_HI:RS1_LO];
  assign rs2    = instr_q[RS2_HI:RS2_LO];
  assign full   = slot_q == SLOT_FULL;
  assign use_a  = full && uses_rs1(op);
  assign use_b  = full && uses_rs2(op);
  assign RA     = use_a ? rs1 : 5'd0;
  assign RB     = use_b ? rs2 : 5'd0;
  assign writes = writes_rd(op) && rd != 5'd0;
  assign hazard = (use_a && busy_a) || (use_b && busy_b) || (writes && sat_rd);
  assign issue  = full && !hazard && !flush && (out_q == OUT_EMPTY || id_ready);
  // A flush frees the slot this cycle, so fetch may refill it at the same edge
  assign if_ready = !full || issue || flush;
  assign accept   = if_valid && if_ready;
  pending_write_scoreboard u_sb (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_en  (issue && writes),
    .inc_idx (rd),
    .dec_en  (wb_enable),
    .dec_idx (wb_rw),
    .qa      (RA),
    .qb      (RB),
    .qrd     (rd),
    .busy_a  (busy_a),
    .busy_b  (busy_b),
    .sat_rd  (sat_rd)
  );
  // Next slot and output-register contents; operands are sampled only at issue
  always_comb begin
    slot_d  = accept ? SLOT_FULL : (issue || flush) ? SLOT_EMPTY : slot_q;
    instr_d = accept ? if_instr : instr_q;
    pc_d    = accept ? if_pc : pc_q;
    out_d   = issue ? OUT_FULL : id_ready ? OUT_EMPTY : out_q;
    pkt_d   = issue ? id_pkt_t'{opcode: op, rd: rd, writes: writes,
                                imm: {{16{instr_q[IMM_HI]}}, instr_q[IMM_HI:IMM_LO]},
                                a: BusA, b: BusB, pc: pc_q} : pkt_q;
  end
  // Slot and output pipeline registers, cleared immediately on reset
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      slot_q  <= SLOT_EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
      out_q   <= OUT_EMPTY;
      pkt_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      pkt_q   <= pkt_d;
    end
  assign id_valid  = out_q == OUT_FULL;
  assign id_opcode = pkt_q.opcode;
  assign id_rd     = pkt_q.rd;
  assign id_writes = pkt_q.writes;
  assign id_imm    = pkt_q.imm;
  assign id_a      = pkt_q.a;
  assign id_b      = pkt_q.b;
  assign id_pc     = pkt_q.pc;
endmodule
